// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// mul/div freeze with timeout, branch flushes and perf counters.
module hazard_stall_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_MultiCycle,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             IF_ID_UsesRs1,
    input  logic             IF_ID_UsesRs2,
    input  logic             BranchTaken_EX,
    input  logic             mc_done,
    output logic             mc_start,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int BW = $clog2(MC_TIMEOUT + 1);

    typedef enum logic {RUN, MC_BUSY} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] busy, busy_nx;
    logic          to_set;
    logic          br_flush;
    logic          load_use;

    assign load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((IF_ID_UsesRs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                       (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));

    // Next-state and pipeline control; reset overrides every event
    always_comb begin
        mc_start     = 1'b0;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        state_nx     = state;
        busy_nx      = busy;
        to_set       = 1'b0;
        br_flush     = 1'b0;
        if (rst) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            state_nx     = RUN;
            busy_nx      = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (BranchTaken_EX) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        br_flush    = 1'b1;
                    end else if (ID_EX_MultiCycle) begin
                        mc_start     = 1'b1;
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        state_nx     = MC_BUSY;
                        busy_nx      = BW'(1);
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (mc_done) begin
                        state_nx = RUN;
                        busy_nx  = '0;
                    end else if (busy < BW'(MC_TIMEOUT)) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        busy_nx      = busy + 1'b1;
                    end else begin
                        to_set   = 1'b1;
                        state_nx = RUN;
                        busy_nx  = '0;
                    end
                end
            endcase
        end
    end

    // FSM state and busy-cycle counter
    always_ff @(posedge clk) begin
        state <= state_nx;
        busy  <= busy_nx;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            mc_timeout <= 1'b0;
        else if (to_set)
            mc_timeout <= 1'b1;
    end

    // Saturating stall and flush counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!PC_Write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (br_flush && (flush_events != '1))
                flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: vector table plus multi-cycle
// sequences, checked against a scoreboard queue and counter model.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

    // {mc_start, PC_W, IF_ID_W, IF_ID_F, ID_EX_W, ID_EX_F, EX_MEM_F}
    localparam logic [6:0] DEF = 7'b0110100;
    localparam logic [6:0] LU  = 7'b0000110;
    localparam logic [6:0] BR  = 7'b0111110;
    localparam logic [6:0] MCE = 7'b1000001;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] RST = 7'b0001011;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [4:0] rd;
        logic       mc;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       done;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, mr, mc, u1, u2, br, done;
    logic [4:0] rd, rs1, rs2;
    logic mc_start, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f;
    logic mc_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    bit exp_to = 1'b0;
    logic [6:0] sb_q[$];
    vec_t tbl[11];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .MC_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .ID_EX_MultiCycle(mc),
        .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
        .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
        .BranchTaken_EX(br), .mc_done(done),
        .mc_start(mc_start), .PC_Write(pc_w),
        .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f),
        .ID_EX_Write(idex_w), .ID_EX_Flush(idex_f),
        .EX_MEM_Flush(exmem_f), .mc_timeout(mc_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    function automatic vec_t mk(
        input logic r, input logic m, input logic [4:0] d,
        input logic c, input logic [4:0] s1, input logic [4:0] s2,
        input logic a1, input logic a2, input logic b,
        input logic dn, input logic [6:0] e);
        vec_t v;
        v.rst = r; v.mr = m; v.rd = d; v.mc = c;
        v.rs1 = s1; v.rs2 = s2; v.u1 = a1; v.u2 = a2;
        v.br = b; v.done = dn; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Called just after a rising edge; covers one full cycle
    task automatic step(input vec_t v, input bit to_set, input string name);
        logic [6:0] e;
        rst = v.rst; mr = v.mr; rd = v.rd; mc = v.mc;
        rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2;
        br = v.br; done = v.done;
        sb_q.push_back(v.exp);
        #3;
        e = sb_q.pop_front();
        chk({name, " ctrl"},
            int'({mc_start, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f}),
            int'(e));
        if (v.rst) begin
            exp_stall = 0;
            exp_flush = 0;
            exp_to    = 1'b0;
        end else begin
            if (!e[5] && exp_stall < 15) exp_stall++;
            if (e[3] && exp_flush < 15) exp_flush++;
            if (to_set) exp_to = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({name, " stall_cycles"}, int'(stall_cycles), exp_stall);
        chk({name, " flush_events"}, int'(flush_events), exp_flush);
        chk({name, " mc_timeout"}, int'(mc_timeout), int'(exp_to));
    endtask

    initial begin
        vec_t rv, idle, mcv, mcd, luv;
        rv   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
        luv  = mk(0, 1, 5, 0, 5, 0, 1, 0, 0, 0, LU);

        tbl[0]  = rv;
        tbl[1]  = idle;
        tbl[2]  = luv;
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, DEF);
        tbl[4]  = mk(0, 1, 7, 0, 3, 7, 1, 1, 0, 0, LU);
        tbl[5]  = mk(0, 1, 7, 0, 3, 7, 1, 0, 0, 0, DEF);
        tbl[6]  = mk(0, 0, 5, 0, 5, 0, 1, 0, 0, 0, DEF);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF);
        tbl[8]  = mk(0, 1, 5, 0, 5, 0, 1, 0, 1, 0, BR);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, BR);
        tbl[10] = mk(0, 1, 6, 0, 5, 4, 1, 1, 0, 0, DEF);

        rst = 1'b1; mr = 0; rd = 0; mc = 0; rs1 = 0; rs2 = 0;
        u1 = 0; u2 = 0; br = 0; done = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++)
            step(tbl[i], 1'b0, $sformatf("vec%0d", i));

        mcv = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, MCE);
        mcd = mcv;
        mcd.exp = FRZ;

        // mul/div completing on the third busy cycle, then a second one
        step(rv, 1'b0, "t3 rst");
        step(mcv, 1'b0, "t3 entry");
        step(mcd, 1'b0, "t3 frz1");
        step(mcd, 1'b0, "t3 frz2");
        mcd.done = 1'b1; mcd.exp = DEF;
        step(mcd, 1'b0, "t3 release");
        step(mcv, 1'b0, "b2b entry");
        mcd.done = 1'b1;
        step(mcd, 1'b0, "b2b release");
        step(idle, 1'b0, "t3 idle");

        // timeout with mc_done never asserted
        mcd.done = 1'b0; mcd.exp = FRZ;
        step(rv, 1'b0, "t4 rst");
        step(mcv, 1'b0, "t4 entry");
        for (int i = 0; i < 3; i++)
            step(mcd, 1'b0, $sformatf("t4 frz%0d", i));
        mcd.exp = DEF;
        step(mcd, 1'b1, "t4 timeout");
        for (int i = 0; i < 3; i++)
            step(idle, 1'b0, "t4 sticky");

        // reset in the second MC_BUSY cycle
        mcd.exp = FRZ;
        step(mcv, 1'b0, "t6 entry");
        step(mcd, 1'b0, "t6 frz");
        rv.mc = 1'b1;
        step(rv, 1'b0, "t6 rst");
        step(idle, 1'b0, "t6 run");

        // saturation of the 4-bit stall counter
        for (int i = 0; i < 20; i++)
            step(luv, 1'b0, $sformatf("t7 lu%0d", i));
        chk("t7 sat", int'(stall_cycles), 15);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
